ts_elastic_stage: RTL and testbench

Parametrised elastic pipeline stage with ingress timestamp tagging, for use between the RX, parser, logic and TX stages. It is a DEPTH-entry FIFO with full-throughput valid/ready handshaking, so it can sustain one transfer per cycle without the bubble a single-register stage introduces. Each accepted word is stored with the `cycle_cnt` value at acceptance. On the output side the block presents that timestamp, the word's dwell age, and a running maximum-age statistic for latency measurement.

---
 rtl/ts_elastic_stage_if.sv | 25 ++
 rtl/ts_elastic_stage.sv | 73 +++++++
 tb/tb_ts_elastic_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ts_elastic_stage_if.sv
// Handshake bundle for ts_elastic_stage: ingress valid/ready plus
// egress valid/ready with the head entry's timestamp and age.
interface ts_elastic_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TS_W   = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ts;
  logic [TS_W-1:0]   out_age;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ts, out_age
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ts, out_age
  );
endinterface

// File: rtl/ts_elastic_stage.sv
// DEPTH-entry elastic FIFO stage that tags each word with cycle_cnt at
// acceptance and reports head timestamp, dwell age and a max-age statistic.
module ts_elastic_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TS_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TS_W-1:0]        cycle_cnt,
  ts_elastic_stage_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   clr_stats,
  output logic [TS_W-1:0]        max_age
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TS_W-1:0]   ts_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [TS_W-1:0]   head_age;

  // Ready looks only at occupancy, so a full stage never admits a word on
  // the same edge that frees a slot.
  assign bus.in_ready  = !rst && (count != FULL);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = data_mem[rd_ptr];
  assign bus.out_ts    = ts_mem[rd_ptr];
  assign bus.out_age   = head_age;

  always_comb begin
    push     = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready && !rst;
    head_age = cycle_cnt - ts_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      ts_mem[wr_ptr]   <= cycle_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      max_age <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A clear coinciding with a pop restarts the statistic from that pop.
      if (pop) begin
        if (clr_stats || (head_age > max_age)) max_age <= head_age;
      end else if (clr_stats) begin
        max_age <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ts_elastic_stage.sv
// Randomised plus directed bench for ts_elastic_stage with a queue-based
// reference model and a negedge monitor.
module tb_ts_elastic_stage;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TS_W   = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [TS_W-1:0]   cycle_cnt;
  logic              clr_stats;
  logic [CNT_W-1:0]  count;
  logic [TS_W-1:0]   max_age;

  ts_elastic_stage_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  ts_elastic_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cycle_cnt (cycle_cnt),
    .bus       (bus),
    .count     (count),
    .clr_stats (clr_stats),
    .max_age   (max_age)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of (payload, timestamp) plus max-age.
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TS_W-1:0]   ts;
  } ent_t;

  ent_t            q[$];
  logic [TS_W-1:0] m_max;
  bit              armed = 1'b0;

  always @(negedge clk) begin
    logic [TS_W-1:0] age;
    bit m_pop;
    bit m_push;
    if (armed) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(!rst && (q.size() != DEPTH)));
      chk("max_age", 64'(max_age), 64'(m_max));
      if (q.size() != 0) begin
        age = cycle_cnt - q[0].ts;
        chk("out_data", 64'(bus.out_data), 64'(q[0].d));
        chk("out_ts", 64'(bus.out_ts), 64'(q[0].ts));
        chk("out_age", 64'(bus.out_age), 64'(age));
      end
    end
    if (rst) begin
      q.delete();
      m_max = '0;
      armed = 1'b1;
    end else begin
      m_pop  = (q.size() != 0) && bus.out_ready;
      m_push = bus.in_valid && (q.size() != DEPTH);
      if (m_pop) begin
        age = cycle_cnt - q[0].ts;
        if (clr_stats || age > m_max) m_max = age;
        void'(q.pop_front());
      end else if (clr_stats) begin
        m_max = '0;
      end
      if (m_push) q.push_back('{d: bus.in_data, ts: cycle_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle_cnt = cycle_cnt + 1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    bus.out_ready = 1'b0;
    clr_stats    = 1'b0;
    cycle_cnt    = 32'd50;

    // reset held with in_valid asserted
    repeat (3) tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // single word, 4-cycle stall
    cycle_cnt = 32'd100;
    bus.in_data = 8'hA5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.out_ready = 1'b1;
    #1;
    chk("stall_out_data", 64'(bus.out_data), 64'hA5);
    chk("stall_out_ts", 64'(bus.out_ts), 64'd100);
    chk("stall_out_age", 64'(bus.out_age), 64'd5);
    tick();
    bus.out_ready = 1'b0;
    chk("stall_max_age", 64'(max_age), 64'd5);

    // streaming
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_data = 8'(i);
      tick();
      chk("stream_count_le1", 64'(count <= 1), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;

    // fill and drain
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(8'h10 + i);
      tick();
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    bus.in_data = 8'h20;
    tick();
    chk("full_pop_push_count", 64'(count), 64'd3);
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);

    // timestamp wrap
    cycle_cnt = 32'hFFFF_FFFE;
    bus.in_data = 8'h77;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.out_ready = 1'b1;
    #1 chk("wrap_out_age", 64'(bus.out_age), 64'd5);
    tick();
    bus.out_ready = 1'b0;

    // statistics clear
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_alone_initial", 64'(max_age), 64'd0);
    bus.in_data = 8'h99;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("max_age_9", 64'(max_age), 64'd9);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_alone", 64'(max_age), 64'd0);
    bus.in_data = 8'h5A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    bus.out_ready = 1'b1;
    clr_stats = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    clr_stats = 1'b0;
    chk("clr_with_pop", 64'(max_age), 64'd3);

    // randomised traffic with occasional resets and counter jumps
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      clr_stats     = ($urandom_range(0, 15) == 0);
      bus.in_data   = 8'($urandom);
      if ($urandom_range(0, 99) == 0) cycle_cnt = $urandom;
      tick();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    clr_stats = 1'b0;
    repeat (DEPTH + 2) tick();
    chk("final_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
